// File: rtl/ureg_defs.sv
// ureg_defs: operation codes shared by the universal register and its next-state logic
package ureg_defs;
    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_INC  = 3'd6;
    localparam logic [2:0] MODE_DEC  = 3'd7;
endpackage

// File: rtl/ureg_next.sv
// ureg_next: combinational next value and carry for every register operation
module ureg_next
    import ureg_defs::*;
#(
    parameter int WIDTH    = 4,
    parameter bit ARITH_EN = 1'b1
) (
    input  logic [WIDTH-1:0] r,
    input  logic             c,
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] r_nxt,
    output logic             c_nxt
);
    // unknown or disabled codes fall through to hold
    always_comb begin
        r_nxt = r;
        c_nxt = c;
        case (mode)
            MODE_LOAD: begin r_nxt = d;                       c_nxt = 1'b0;     end
            MODE_SHL:  begin r_nxt = {r[WIDTH-2:0], sin_l};   c_nxt = r[WIDTH-1]; end
            MODE_SHR:  begin r_nxt = {sin_r, r[WIDTH-1:1]};   c_nxt = r[0];     end
            MODE_ROL:  begin r_nxt = {r[WIDTH-2:0], r[WIDTH-1]}; c_nxt = r[WIDTH-1]; end
            MODE_ROR:  begin r_nxt = {r[0], r[WIDTH-1:1]};    c_nxt = r[0];     end
            MODE_INC:  if (ARITH_EN) begin r_nxt = r + WIDTH'(1); c_nxt = &r;   end
            MODE_DEC:  if (ARITH_EN) begin r_nxt = r - WIDTH'(1); c_nxt = ~|r;  end
            default:   ;
        endcase
    end
endmodule

// File: rtl/universal_register.sv
// universal_register: WIDTH-bit load/shift/rotate/count register with carry flag and tri-state view
module universal_register
    import ureg_defs::*;
#(
    parameter int             WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit             ARITH_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             oe,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_int,
    output logic             sout_l,
    output logic             sout_r,
    output logic             carry
);
    logic [WIDTH-1:0] r = RESET_VAL;
    logic             c = 1'b0;
    logic [WIDTH-1:0] r_nxt;
    logic             c_nxt;
    ureg_next #(.WIDTH(WIDTH), .ARITH_EN(ARITH_EN)) u_next (
        .r(r), .c(c), .d(d), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
        .r_nxt(r_nxt), .c_nxt(c_nxt)
    );
    always_ff @(posedge clk) begin
        if (clr) begin
            r <= RESET_VAL;
            c <= 1'b0;
        end else if (en) begin
            r <= r_nxt;
            c <= c_nxt;
        end
    end
    assign q      = oe ? r : 'z;
    assign q_int  = r;
    assign sout_l = r[WIDTH-1];
    assign sout_r = r[0];
    assign carry  = c;
endmodule
